// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the sequential multiplier
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/product handshake bundle for seq_multiplier
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, mcand, mplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mcand, mplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_multiplier_adder.sv
// rtl/seq_multiplier_adder.sv - Kogge-Stone parallel-prefix adder used per iteration
module adder #(
  parameter int WIDTH = 32,
  parameter int DELAY = 50
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  if (DELAY <= 0) begin : g_bad_delay
    $error("adder: DELAY must be positive");
  end

  // Prefix tree evaluated inside a function so each level is a fresh local vector.
  function automatic logic [WIDTH:0] ks_add(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic             ci);
    logic [WIDTH-1:0] g, p, gn, pn, p0;
    logic [WIDTH:0]   c;
    g  = x & y;
    p  = x ^ y;
    p0 = p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < WIDTH; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
    return {c[WIDTH], p0 ^ c[WIDTH-1:0]};
  endfunction

  always_comb begin
    {cout, sum} = ks_add(a, b, cin);
  end
endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1,
  parameter int DELAY = 50
) (
  input logic             clk,
  input logic             rst_n,
  seq_multiplier_if.slave bus
);
  mult_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, mcand_r;
  logic [WIDTH-1:0] add_b, add_sum;
  logic             add_cout;
  logic             in_ready_r, out_valid_r, busy_r;

  adder #(.WIDTH(WIDTH), .DELAY(DELAY)) u_add (
    .a   (hi),
    .b   (add_b),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    add_b = lo[0] ? mcand_r : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      mcand_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_r  <= (state_nxt == IDLE);
      out_valid_r <= (state_nxt == DONE);
      busy_r      <= (state_nxt == RUN);
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_r <= bus.mcand;
            lo      <= bus.mplier;
            hi      <= '0;
            cnt     <= '0;
          end
        end
        RUN: begin
          // Carry-out lands in hi's MSB; the consumed multiplier bit falls off lo.
          {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
          cnt      <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.product   = {hi, lo};
endmodule
